cmp_stream_tracker: RTL and testbench
=====================================

Name: cmp_stream_tracker

Overview:
- Streaming stage directly downstream of the combinational N-bit comparator; comparator outputs are consumed here every cycle.
- Accepts a frame of unsigned N-bit samples over a valid/ready handshake.
- Per frame, tracks the running max and min, and counts samples equal to, lower than and greater than a per-frame target.
- At frame end, presents one result record over a second valid/ready handshake.

Parameters:
- N, 4, sample and target width in bits (unsigned).
- CNT_W, 8, width of every counter; counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  sample present.
- in_ready  output  1  stage can accept a sample.
- in_data  input  N  sample value.
- in_last  input  1  sample is the final one of its frame.
- target  input  N  compare target; sampled only on the first beat of a frame.
- out_valid  output  1  result record valid.
- out_ready  input  1  consumer accepts the record.
- out_max  output  N  largest sample in the frame.
- out_min  output  N  smallest sample in the frame.
- out_eq_cnt  output  CNT_W  count of samples == target.
- out_lw_cnt  output  CNT_W  count of samples < target.
- out_gr_cnt  output  CNT_W  count of samples > target.
- out_count  output  CNT_W  total samples in the frame.
- out_sat  output  1  set if any counter saturated during the frame.

Behaviour:
- Reset (async, rst_n=0): state goes to IDLE.
  - All out_* registers are 0, out_valid=0, in_ready=1.
  - Internal max, min, target_q and counters are cleared.
- Accept event: in_valid && in_ready, evaluated on the rising clk edge.
- States: IDLE, ACCUM, REPORT.
  - in_ready=1 in IDLE and ACCUM, 0 in REPORT.
  - out_valid=1 only in REPORT; it is a registered output.
- IDLE, on accept:
  - target_q <= target; max <= in_data; min <= in_data; count <= 1.
  - Exactly one of eq/lw/gr counters <= 1, chosen by comparing in_data against the live target input. The other two <= 0.
  - If in_last: go to REPORT; else go to ACCUM.
- ACCUM, on accept:
  - Compare in_data against target_q; increment the matching eq/lw/gr counter.
  - If in_data > max: max <= in_data.
  - If in_data < min: min <= in_data.
  - Increment count.
  - If in_last: go to REPORT.
  - No accept: hold all state.
- Saturation:
  - A counter at 2^CNT_W-1 holds its value; the event sets a sticky sat flag for the frame.
  - count saturates the same way.
  - max/min tracking continues after saturation.
- Outputs are loaded on the transition into REPORT.
  - Latency: out_valid rises on the cycle after the accepted in_last beat.
  - The result reflects the final beat.
- REPORT:
  - out_* are held stable while out_valid=1 && out_ready=0.
  - in_valid is ignored and no sample is consumed.
  - On out_ready=1: go to IDLE. out_valid=0 and in_ready=1 on the next cycle.
  - out_* data keep their last values after the handshake.
  - No same-cycle pass-through: a new frame's first beat is accepted one cycle after the report handshake.
- Width and arithmetic:
  - All compares are unsigned N-bit.
  - The counter sum eq+lw+gr equals count unless out_sat=1.
- Boundaries:
  - A single-beat frame (in_last on the first beat) is legal; it yields max=min=in_data and count=1.
  - Values 0 and 2^N-1 must be tracked correctly as both max and min.
  - in_valid gaps inside a frame are legal.
- Reset mid-frame or mid-REPORT: the partial frame is discarded with no record emitted; the block returns to the reset state immediately.
- in_data, in_last and target are don't-care when in_valid=0.

Decomposition:
- Shared package:
  - State enum (IDLE/ACCUM/REPORT).
  - Default N and CNT_W constants.
  - A saturating-increment function used by all counters.
- Sub-module: reuse the existing comparator (ports a, b, equal, lower, greater), instantiated three times:
  - in_data vs target (target mux selects the live target in IDLE, target_q in ACCUM).
  - in_data vs max.
  - in_data vs min.
- No other sub-modules.

Test Plan:
- Frame 3,9,9,1 with target=9 (in_last on 1) -> one cycle later out_valid=1; max=9, min=1, eq=2, lw=2, gr=0, count=4, sat=0.
- Single beat in_data=5, target=5, in_last=1 -> max=5, min=5, eq=1, lw=0, gr=0, count=1.
- Frame 0,15 with target=7, then hold out_ready=0 for 5 cycles -> out_* stable at max=15, min=0, lw=1, gr=1. in_ready=0 and in_valid pulses are not consumed. Then out_ready=1 -> IDLE next cycle.
- CNT_W=3, 10 beats of 0 with target=0 -> eq=7, count=7, sat=1, max=min=0.
- Assert rst_n=0 after 2 beats of a frame -> all outputs 0 asynchronously, no record emitted. The following frame 4,2 with target=3 -> max=4, min=2, lw=1, gr=1, count=2.
- Exhaustive sweep: for each target 0..15, a frame of samples 0..15 with random in_valid gaps -> eq=1, lw=target, gr=15-target, max=15, min=0, count=16 every frame.

Source files
------------

// File: rtl/cmp_stream_tracker_pkg.sv
// Shared types and helpers for the comparator stream tracker.
// State encoding, default widths and the saturating increment.
package cmp_stream_tracker_pkg;

  localparam int N_DEF     = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    REPORT
  } state_e;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] lim
  );
    return (v == lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cmp_stream_tracker_cmp.sv
// Unsigned N-bit magnitude comparator.
// Exactly one of equal/lower/greater is high.
module cmp_stream_tracker_cmp #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         equal,
  output logic         lower,
  output logic         greater
);

  assign equal   = (a == b);
  assign lower   = (a < b);
  assign greater = (a > b);

endmodule

// File: rtl/cmp_stream_tracker.sv
// Per-frame max/min and eq/lw/gr counting against a target.
// One result record is emitted per frame over a valid/ready port.
module cmp_stream_tracker
  import cmp_stream_tracker_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  input  logic [N-1:0]     target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_max,
  output logic [N-1:0]     out_min,
  output logic [CNT_W-1:0] out_eq_cnt,
  output logic [CNT_W-1:0] out_lw_cnt,
  output logic [CNT_W-1:0] out_gr_cnt,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0]      LIM     = 32'(CNT_MAX);

  state_e           state;
  logic [N-1:0]     target_q, max_q, min_q;
  logic [CNT_W-1:0] eq_q, lw_q, gr_q, cnt_q;
  logic             sat_q;

  logic [N-1:0]     max_n, min_n, tgt_sel;
  logic [CNT_W-1:0] eq_n, lw_n, gr_n, cnt_n;
  logic             sat_n;

  logic t_eq, t_lw, t_gr;
  logic mx_eq, mx_lw, mx_gr;
  logic mn_eq, mn_lw, mn_gr;
  logic unused_cmp;
  logic accept;

  assign in_ready = (state != REPORT);
  assign accept   = in_valid && in_ready;
  assign tgt_sel  = (state == IDLE) ? target : target_q;

  cmp_stream_tracker_cmp #(.N(N)) u_cmp_tgt (
    .a(in_data), .b(tgt_sel),
    .equal(t_eq), .lower(t_lw), .greater(t_gr)
  );

  cmp_stream_tracker_cmp #(.N(N)) u_cmp_max (
    .a(in_data), .b(max_q),
    .equal(mx_eq), .lower(mx_lw), .greater(mx_gr)
  );

  cmp_stream_tracker_cmp #(.N(N)) u_cmp_min (
    .a(in_data), .b(min_q),
    .equal(mn_eq), .lower(mn_lw), .greater(mn_gr)
  );

  assign unused_cmp = ^{mx_eq, mx_lw, mn_eq, mn_gr};

  always_comb begin
    max_n = max_q;
    min_n = min_q;
    eq_n  = eq_q;
    lw_n  = lw_q;
    gr_n  = gr_q;
    cnt_n = cnt_q;
    sat_n = sat_q;
    if (state == IDLE) begin
      max_n = in_data;
      min_n = in_data;
      eq_n  = CNT_W'(t_eq);
      lw_n  = CNT_W'(t_lw);
      gr_n  = CNT_W'(t_gr);
      cnt_n = CNT_W'(1);
      sat_n = 1'b0;
    end else begin
      if (mx_gr) max_n = in_data;
      if (mn_lw) min_n = in_data;
      if (t_eq) eq_n = CNT_W'(sat_inc(32'(eq_q), LIM));
      if (t_lw) lw_n = CNT_W'(sat_inc(32'(lw_q), LIM));
      if (t_gr) gr_n = CNT_W'(sat_inc(32'(gr_q), LIM));
      cnt_n = CNT_W'(sat_inc(32'(cnt_q), LIM));
      // sticky: any increment attempted at the ceiling
      sat_n = sat_q
            | (t_eq && eq_q == CNT_MAX)
            | (t_lw && lw_q == CNT_MAX)
            | (t_gr && gr_q == CNT_MAX)
            | (cnt_q == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      target_q   <= '0;
      max_q      <= '0;
      min_q      <= '0;
      eq_q       <= '0;
      lw_q       <= '0;
      gr_q       <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      out_valid  <= 1'b0;
      out_max    <= '0;
      out_min    <= '0;
      out_eq_cnt <= '0;
      out_lw_cnt <= '0;
      out_gr_cnt <= '0;
      out_count  <= '0;
      out_sat    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if (state == IDLE) target_q <= target;
            max_q <= max_n;
            min_q <= min_n;
            eq_q  <= eq_n;
            lw_q  <= lw_n;
            gr_q  <= gr_n;
            cnt_q <= cnt_n;
            sat_q <= sat_n;
            if (in_last) begin
              state      <= REPORT;
              out_valid  <= 1'b1;
              out_max    <= max_n;
              out_min    <= min_n;
              out_eq_cnt <= eq_n;
              out_lw_cnt <= lw_n;
              out_gr_cnt <= gr_n;
              out_count  <= cnt_n;
              out_sat    <= sat_n;
            end else begin
              state <= ACCUM;
            end
          end
        end
        REPORT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_stream_tracker.sv
// Directed bench for cmp_stream_tracker (CNT_W=8 and CNT_W=3 instances).
// Records are compared as packed concatenations of all out_* fields.
module tb_cmp_stream_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_data = '0;
  logic [3:0] target = '0;

  logic       in_ready, out_valid, out_sat;
  logic [3:0] out_max, out_min;
  logic [7:0] out_eq_cnt, out_lw_cnt, out_gr_cnt, out_count;

  logic       in_ready3, out_valid3, out_sat3;
  logic [3:0] out_max3, out_min3;
  logic [2:0] out_eq_cnt3, out_lw_cnt3, out_gr_cnt3, out_count3;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cmp_stream_tracker #(.N(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .target(target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_min(out_min),
    .out_eq_cnt(out_eq_cnt), .out_lw_cnt(out_lw_cnt),
    .out_gr_cnt(out_gr_cnt), .out_count(out_count),
    .out_sat(out_sat)
  );

  cmp_stream_tracker #(.N(4), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .in_last(in_last), .target(target),
    .out_valid(out_valid3), .out_ready(out_ready),
    .out_max(out_max3), .out_min(out_min3),
    .out_eq_cnt(out_eq_cnt3), .out_lw_cnt(out_lw_cnt3),
    .out_gr_cnt(out_gr_cnt3), .out_count(out_count3),
    .out_sat(out_sat3)
  );

  wire [40:0] rec = {out_max, out_min, out_eq_cnt, out_lw_cnt,
                     out_gr_cnt, out_count, out_sat};
  wire [20:0] rec3 = {out_max3, out_min3, out_eq_cnt3, out_lw_cnt3,
                      out_gr_cnt3, out_count3, out_sat3};

  task automatic beat(input logic [3:0] d, input logic [3:0] t,
                      input logic last);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; fails++;
      $display("FAIL beat_wait: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1; in_data = d; target = t; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({out_valid, in_ready, rec} !== {1'b0, 1'b1, 41'd0}) begin
      fails++;
      $display("FAIL reset: got v=%0b r=%0b rec=%h required v=0 r=1 rec=0",
               out_valid, in_ready, rec);
    end
    checks++;
    if ({out_valid3, in_ready3, rec3} !== {1'b0, 1'b1, 21'd0}) begin
      fails++;
      $display("FAIL reset3: got v=%0b r=%0b rec=%h required v=0 r=1 rec=0",
               out_valid3, in_ready3, rec3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [40:0] exp;
    exp = {4'd9, 4'd1, 8'd2, 8'd2, 8'd0, 8'd4, 1'b0};
    beat(4'd3, 4'd9, 1'b0);
    beat(4'd9, 4'd0, 1'b0);
    beat(4'd9, 4'd0, 1'b0);
    beat(4'd1, 4'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL basic_latency: out_valid=%0b required 1", out_valid);
    end
    checks++;
    if (rec !== exp) begin
      fails++;
      $display("FAIL basic_rec: got %h required %h", rec, exp);
    end
    ack();
    checks++;
    if ({out_valid, in_ready, rec} !== {1'b0, 1'b1, exp}) begin
      fails++;
      $display("FAIL basic_ack: got v=%0b r=%0b rec=%h required v=0 r=1 rec=%h",
               out_valid, in_ready, rec, exp);
    end
  endtask

  task automatic test_single();
    logic [40:0] exp;
    exp = {4'd5, 4'd5, 8'd1, 8'd0, 8'd0, 8'd1, 1'b0};
    beat(4'd5, 4'd5, 1'b1);
    checks++;
    if ({out_valid, rec} !== {1'b1, exp}) begin
      fails++;
      $display("FAIL single: got v=%0b rec=%h required v=1 rec=%h",
               out_valid, rec, exp);
    end
    ack();
  endtask

  task automatic test_backpressure();
    logic [40:0] exp;
    exp = {4'd15, 4'd0, 8'd0, 8'd1, 8'd1, 8'd2, 1'b0};
    beat(4'd0, 4'd7, 1'b0);
    beat(4'd15, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 4'd3; target = 4'd3; in_last = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, rec} !== {1'b1, 1'b0, exp}) begin
        fails++;
        $display("FAIL bp_hold%0d: got v=%0b r=%0b rec=%h required v=1 r=0 rec=%h",
                 i, out_valid, in_ready, rec, exp);
      end
    end
    in_data = 4'd8;
    ack();
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if ({out_valid, in_ready, rec} !== {1'b0, 1'b1, exp}) begin
      fails++;
      $display("FAIL bp_ack: got v=%0b r=%0b rec=%h required v=0 r=1 rec=%h",
               out_valid, in_ready, rec, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_no_passthru: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    logic [40:0] exp;
    logic [20:0] exp3;
    exp  = {4'd0, 4'd0, 8'd10, 8'd0, 8'd0, 8'd10, 1'b0};
    exp3 = {4'd0, 4'd0, 3'd7, 3'd0, 3'd0, 3'd7, 1'b1};
    for (int i = 0; i < 10; i++) beat(4'd0, 4'd0, i == 9);
    checks++;
    if ({out_valid3, rec3} !== {1'b1, exp3}) begin
      fails++;
      $display("FAIL sat_cnt3: got v=%0b rec=%h required v=1 rec=%h",
               out_valid3, rec3, exp3);
    end
    checks++;
    if (rec !== exp) begin
      fails++;
      $display("FAIL sat_cnt8: got %h required %h", rec, exp);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    logic [40:0] exp;
    exp = {4'd4, 4'd2, 8'd0, 8'd1, 8'd1, 8'd2, 1'b0};
    beat(4'd6, 4'd3, 1'b0);
    beat(4'd6, 4'd3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, rec} !== {1'b0, 1'b1, 41'd0}) begin
      fails++;
      $display("FAIL rst_mid: got v=%0b r=%0b rec=%h required v=0 r=1 rec=0",
               out_valid, in_ready, rec);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_no_rec: out_valid=%0b required 0", out_valid);
    end
    beat(4'd4, 4'd3, 1'b0);
    beat(4'd2, 4'd3, 1'b1);
    checks++;
    if ({out_valid, rec} !== {1'b1, exp}) begin
      fails++;
      $display("FAIL rst_next: got v=%0b rec=%h required v=1 rec=%h",
               out_valid, rec, exp);
    end
    ack();
  endtask

  task automatic test_sweep();
    logic [40:0] exp;
    logic [3:0]  t, d;
    for (int ti = 0; ti < 16; ti++) begin
      t = 4'(ti);
      exp = {4'd15, 4'd0, 8'd1, 8'(ti), 8'(15 - ti), 8'd16, 1'b0};
      for (int i = 0; i < 16; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        d = t[0] ? 4'(15 - i) : 4'(i);
        beat(d, (i == 0) ? t : ~t, i == 15);
      end
      checks++;
      if ({out_valid, rec} !== {1'b1, exp}) begin
        fails++;
        $display("FAIL sweep_t%0d: got v=%0b rec=%h required v=1 rec=%h",
                 ti, out_valid, rec, exp);
      end
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
